// File: rtl/onehot_decoder_pipe.sv
// Registered binary-index to one-hot decoder with valid/ready handshakes,
// a 2-entry output FIFO, out-of-range flagging and a saturating error counter.

module onehot_decoder_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic             o_bit
);
  assign o_bit = i_en && (int'(i_idx) == LANE);
endmodule

module onehot_decoder_pipe #(
  parameter int IDX_W = 2,
  parameter int N     = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);
  typedef struct packed {
    logic [N-1:0] oh;
    logic         err;
  } ent_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

  cnt_e             r_cnt;
  ent_t             r_hd, r_tl;
  logic [ERR_W-1:0] r_err_cnt;
  logic [N-1:0]     w_hit;
  ent_t             w_dec;
  logic             w_push, w_pop;

  // Indices at or above N have no lane, so they fall through to an all-zero word.
  for (genvar g = 0; g < N; g++) begin : g_lane
    onehot_decoder_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .i_idx (in_idx),
      .i_en  (in_en),
      .o_bit (w_hit[g])
    );
  end

  always_comb begin
    w_dec     = '0;
    w_dec.oh  = w_hit;
    w_dec.err = in_en && (int'(in_idx) >= N);
  end

  assign in_ready   = (r_cnt != FULL);
  assign out_valid  = (r_cnt != EMPTY);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign out_onehot = r_hd.oh;
  assign out_err    = r_hd.err;
  assign err_cnt    = r_err_cnt;

  // Head is cleared when the buffer drains so idle outputs read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= EMPTY;
      r_hd  <= '0;
      r_tl  <= '0;
    end else begin
      case (r_cnt)
        EMPTY: if (w_push) begin
          r_hd  <= w_dec;
          r_cnt <= ONE;
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_hd <= w_dec;
          end else if (w_push) begin
            r_tl  <= w_dec;
            r_cnt <= FULL;
          end else if (w_pop) begin
            r_hd  <= '0;
            r_cnt <= EMPTY;
          end
        end
        FULL: if (w_pop) begin
          r_hd  <= r_tl;
          r_cnt <= ONE;
        end
        default: r_cnt <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (w_push && w_dec.err && (r_err_cnt != {ERR_W{1'b1}}))
      r_err_cnt <= r_err_cnt + 1'b1;
  end
endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: vector table on an N=4 instance, queue-model
// random and saturation runs on an N=3 instance, then a mid-cycle reset.

module tb_onehot_decoder_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv4 = 0, ir4, en4 = 0, ov4, ordy4 = 0, oe4;
  logic [1:0] idx4 = 0;
  logic [3:0] oh4;
  logic [7:0] cnt4;

  logic       iv3 = 0, ir3, en3 = 0, ov3, ordy3 = 0, oe3;
  logic [1:0] idx3 = 0;
  logic [2:0] oh3;
  logic [7:0] cnt3;

  onehot_decoder_pipe #(.IDX_W(2), .N(4), .ERR_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_idx(idx4),
    .in_en(en4), .out_valid(ov4), .out_ready(ordy4), .out_onehot(oh4),
    .out_err(oe4), .err_cnt(cnt4));

  onehot_decoder_pipe #(.IDX_W(2), .N(3), .ERR_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_idx(idx3),
    .in_en(en3), .out_valid(ov3), .out_ready(ordy3), .out_onehot(oh3),
    .out_err(oe3), .err_cnt(cnt3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic       en;
    logic       ordy;
    logic       ev;
    logic [3:0] eoh;
    logic       ee;
    logic       erdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] idx, input logic en,
                              input logic ordy, input logic ev, input logic [3:0] eoh,
                              input logic ee, input logic erdy);
    vec_t r;
    r.v = v; r.idx = idx; r.en = en; r.ordy = ordy;
    r.ev = ev; r.eoh = eoh; r.ee = ee; r.erdy = erdy;
    return r;
  endfunction

  vec_t tbl[11];

  // Reference for dut3: FIFO of decoded words, err in bit 8.
  int mq[$];
  int mcnt = 0;

  task automatic beat3(input logic v, input logic [1:0] idx, input logic en, input logic ordy);
    bit mpush, mpop;
    int code;
    iv3 = v; idx3 = idx; en3 = en; ordy3 = ordy;
    mpush = v && (mq.size() < 2);
    mpop  = ordy && (mq.size() > 0);
    if (!en)          code = 0;
    else if (idx < 3) code = 1 << idx;
    else              code = 256;
    @(posedge clk); #1;
    if (mpop) void'(mq.pop_front());
    if (mpush) begin
      mq.push_back(code);
      if (code == 256 && mcnt < 255) mcnt++;
    end
    chk("ovalid3", int'(ov3), int'(mq.size() > 0));
    chk("onehot3", int'(oh3), mq.size() > 0 ? (mq[0] & 7) : 0);
    chk("oerr3",   int'(oe3), mq.size() > 0 ? (mq[0] >> 8) : 0);
    chk("irdy3",   int'(ir3), int'(mq.size() < 2));
    chk("errcnt3", int'(cnt3), mcnt);
  endtask

  initial begin
    logic       rv, ren, rordy;
    logic [1:0] ridx;

    tbl[0]  = mk(1, 0, 1, 1, 1, 4'b0001, 0, 1);
    tbl[1]  = mk(1, 1, 1, 1, 1, 4'b0010, 0, 1);
    tbl[2]  = mk(1, 2, 1, 1, 1, 4'b0100, 0, 1);
    tbl[3]  = mk(1, 3, 1, 1, 1, 4'b1000, 0, 1);
    tbl[4]  = mk(0, 0, 0, 1, 0, 4'b0000, 0, 1);
    tbl[5]  = mk(1, 2, 1, 0, 1, 4'b0100, 0, 1);
    tbl[6]  = mk(1, 1, 1, 0, 1, 4'b0100, 0, 0);
    tbl[7]  = mk(0, 0, 0, 1, 1, 4'b0010, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 4'b0000, 0, 1);
    tbl[9]  = mk(1, 3, 0, 1, 1, 4'b0000, 0, 1);
    tbl[10] = mk(0, 0, 0, 1, 0, 4'b0000, 0, 1);

    #12;
    chk("rst_ovalid4", int'(ov4), 0);
    chk("rst_onehot4", int'(oh4), 0);
    chk("rst_oerr4",   int'(oe4), 0);
    chk("rst_errcnt4", int'(cnt4), 0);
    chk("rst_irdy4",   int'(ir4), 1);
    chk("rst_ovalid3", int'(ov3), 0);
    chk("rst_errcnt3", int'(cnt3), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      iv4 = tbl[i].v; idx4 = tbl[i].idx; en4 = tbl[i].en; ordy4 = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ovalid", i), int'(ov4), int'(tbl[i].ev));
      chk($sformatf("vec%0d_onehot", i), int'(oh4), int'(tbl[i].eoh));
      chk($sformatf("vec%0d_oerr", i),   int'(oe4), int'(tbl[i].ee));
      chk($sformatf("vec%0d_irdy", i),   int'(ir4), int'(tbl[i].erdy));
      chk($sformatf("vec%0d_errcnt", i), int'(cnt4), 0);
    end
    iv4 = 0; en4 = 0; ordy4 = 1;

    // Out-of-range index on the N=3 instance.
    beat3(1, 3, 1, 1);
    chk("oor_onehot", int'(oh3), 0);
    chk("oor_err",    int'(oe3), 1);
    chk("oor_errcnt", int'(cnt3), 1);
    beat3(0, 0, 0, 1);

    rv = 0; ridx = 0; ren = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(rv && mq.size() >= 2)) begin
        rv   = ($urandom_range(0, 3) != 0);
        ridx = 2'($urandom_range(0, 3));
        ren  = ($urandom_range(0, 4) != 0);
      end
      rordy = ($urandom_range(0, 2) != 0);
      beat3(rv, ridx, ren, rordy);
    end

    for (int i = 0; i < 300; i++) beat3(1, 3, 1, 1);
    chk("sat_errcnt", int'(cnt3), 255);

    // Fill both buffers, then reset between edges.
    iv4 = 1; idx4 = 2; en4 = 1; ordy4 = 0;
    beat3(1, 3, 1, 0);
    beat3(1, 3, 1, 0);
    iv4 = 0;
    chk("full_irdy4", int'(ir4), 0);
    chk("full_irdy3", int'(ir3), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid4", int'(ov4), 0);
    chk("mid_rst_irdy4",   int'(ir4), 1);
    chk("mid_rst_onehot4", int'(oh4), 0);
    chk("mid_rst_ovalid3", int'(ov3), 0);
    chk("mid_rst_errcnt3", int'(cnt3), 0);
    chk("mid_rst_oerr3",   int'(oe3), 0);
    mq.delete();
    mcnt = 0;
    iv3 = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    iv4 = 1; idx4 = 1; en4 = 1; ordy4 = 1;
    beat3(1, 1, 1, 1);
    iv4 = 0;
    chk("post_rst_onehot4", int'(oh4), 2);
    chk("post_rst_ovalid4", int'(ov4), 1);
    chk("post_rst_onehot3", int'(oh3), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
